// File: rtl/mux_scan_seq.sv
//============================================================================
// Module      : mux_scan_seq
// Description : Channel scan sequencer for an 8:1 mux. Walks the enabled
//               channels of a latched mask in ascending order, holds each
//               select for DWELL cycles, captures the mux output on the last
//               dwell cycle and presents the 8-bit snapshot on a
//               valid/ready handshake.
// Option      : MUX_SCAN_CONT_EN - continuous rescan after each handshake
//               while start is held high.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module mux_scan_seq #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] mask,
  output logic [2:0] sel,
  input  logic       x_in,
  output logic       busy,
  output logic [7:0] sample,
  output logic       sample_valid,
  input  logic       sample_ready
);

  // Counter is wide enough to reach DWELL-1; a DWELL of 1 still needs one bit.
  localparam int             CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DWELL = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [7:0]    mask_q;

  logic          start_ok;
  logic          dwell_last;
  logic          handshake;
  logic          restart;
  logic [2:0]    first_sel;
  logic [2:0]    relaunch_sel;
  logic [3:0]    next_info;
  logic          next_found;
  logic [2:0]    next_sel;

  // Lowest set bit of a mask; 0 when the mask is empty.
  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_set = 3'(i);
    end
  endfunction

  // {found, index} of the lowest set bit strictly above cur.
  function automatic logic [3:0] next_set(input logic [7:0] m, input logic [2:0] cur);
    next_set = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) next_set = {1'b1, 3'(i)};
    end
  endfunction

  // Decode of the current step: start acceptance, last dwell cycle, next channel.
  always_comb begin
    start_ok     = (state == S_IDLE) && start && (mask != 8'h00);
    dwell_last   = (cnt == CNT_LAST);
    handshake    = (state == S_OUT) && sample_ready;
    first_sel    = lowest_set(mask);
    relaunch_sel = lowest_set(mask_q);
    next_info    = next_set(mask_q, sel);
    next_found   = next_info[3];
    next_sel     = next_info[2:0];
`ifdef MUX_SCAN_CONT_EN
    // start acts as a run level: held high through the handshake keeps scanning.
    restart      = handshake && start;
`else
    restart      = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_ok) state_nxt = S_DWELL;
      end
      S_DWELL: begin
        if (dwell_last && !next_found) state_nxt = S_OUT;
      end
      S_OUT: begin
        if (restart)        state_nxt = S_DWELL;
        else if (handshake) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; the handshake sees valid only in OUT.
  always_comb begin
    busy         = (state == S_DWELL) || (state == S_OUT);
    sample_valid = (state == S_OUT);
  end

  // Scan datapath: mask latch, select walk, dwell counter and capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= 8'h00;
      sel    <= 3'd0;
      cnt    <= '0;
      sample <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            mask_q <= mask;
            sample <= 8'h00;
            sel    <= first_sel;
            cnt    <= '0;
          end
        end
        S_DWELL: begin
          if (dwell_last) begin
            // Capture on the final dwell cycle so the mux has settled.
            sample[sel] <= x_in;
            cnt         <= '0;
            if (next_found) sel <= next_sel;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_OUT: begin
          // sel and sample stay frozen for the consumer unless rescanning.
          if (restart) begin
            sample <= 8'h00;
            sel    <= relaunch_sel;
            cnt    <= '0;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_seq.sv
//============================================================================
// Module      : tb_mux_scan_seq
// Description : Self-checking bench for mux_scan_seq with DWELL=4 and DWELL=1
//               instances, a behavioural 8:1 mux and a snapshot scoreboard.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_mux_scan_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared stimulus, steered to one instance at a time by 'which'.
  logic       which;
  logic       start_v;
  logic       ready_v;
  logic [7:0] mask_v;
  logic [7:0] data_v;

  logic       start4, ready4, x4, busy4, valid4;
  logic [2:0] sel4;
  logic [7:0] sample4;
  logic       start1, ready1, x1, busy1, valid1;
  logic [2:0] sel1;
  logic [7:0] sample1;

  logic       cur_busy, cur_valid;
  logic [2:0] cur_sel;
  logic [7:0] cur_sample;

  assign start4 = start_v & ~which;
  assign ready4 = ready_v & ~which;
  assign start1 = start_v & which;
  assign ready1 = ready_v & which;
  assign x4     = data_v[sel4];
  assign x1     = data_v[sel1];

  assign cur_busy   = which ? busy1   : busy4;
  assign cur_valid  = which ? valid1  : valid4;
  assign cur_sel    = which ? sel1    : sel4;
  assign cur_sample = which ? sample1 : sample4;

  mux_scan_seq #(.DWELL(4)) dut (
    .clk(clk), .rst(rst), .start(start4), .mask(mask_v), .sel(sel4), .x_in(x4),
    .busy(busy4), .sample(sample4), .sample_valid(valid4), .sample_ready(ready4)
  );

  mux_scan_seq #(.DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mask(mask_v), .sel(sel1), .x_in(x1),
    .busy(busy1), .sample(sample1), .sample_valid(valid1), .sample_ready(ready1)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // One scan on instance w: start with mask m, mux data d, switch mask to
  // m_late after acceptance, hold off ready for bp cycles, then handshake.
  // With chain=1 start is driven on the current negedge (IDLE just entered).
  task automatic scan(input logic w, input logic [7:0] m, input logic [7:0] d,
                      input logic [7:0] m_late, input int bp, input bit chain);
    int ch[$];
    int dw, k, j, e;
    bit seen;
    logic [7:0] held_s, exp_s;
    logic [2:0] held_sel;
    dw = w ? 1 : 4;
    for (int i = 0; i < 8; i++) if (m[i]) ch.push_back(i);
    k = ch.size();
    exp_q.push_back(d & m);
    if (!chain) @(negedge clk);
    which = w; data_v = d; mask_v = m; start_v = 1'b1; ready_v = 1'b0;
    @(negedge clk);
    start_v = 1'b0; mask_v = m_late;
    j = 1;
    checks++;
    if (cur_busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_start: got %b expected 1", cur_busy);
    end
    seen = 0;
    while (j <= k * dw + 5) begin
      if (cur_valid === 1'b1) begin
        seen = 1;
        break;
      end
      if (j <= k * dw) begin
        e = ch[(j - 1) / dw];
        checks++;
        if (cur_sel !== e[2:0]) begin
          errors++; $display("FAIL sel_walk cycle T+%0d: got %0d expected %0d", j, cur_sel, e);
        end
      end
      j++;
      @(negedge clk);
    end
    checks++;
    if (!seen || j != k * dw + 1) begin
      errors++; $display("FAIL valid_latency: got T+%0d (seen=%0b) expected T+%0d", j, seen, k * dw + 1);
    end
    if (!seen) begin
      void'(exp_q.pop_front());
      return;
    end
    held_s = cur_sample; held_sel = cur_sel;
    repeat (bp) begin
      start_v = 1'b1;
      @(negedge clk);
      start_v = 1'b0;
      checks++;
      if (cur_valid !== 1'b1 || cur_sample !== held_s || cur_sel !== held_sel) begin
        errors++;
        $display("FAIL out_stable: got valid=%b sample=%h sel=%0d expected valid=1 sample=%h sel=%0d",
                 cur_valid, cur_sample, cur_sel, held_s, held_sel);
      end
    end
    ready_v = 1'b1;
    exp_s = exp_q.pop_front();
    checks++;
    if (cur_sample !== exp_s) begin
      errors++; $display("FAIL snapshot: got %h expected %h", cur_sample, exp_s);
    end
    @(negedge clk);
    ready_v = 1'b0;
    checks++;
    if (cur_busy !== 1'b0 || cur_valid !== 1'b0) begin
      errors++; $display("FAIL back_to_idle: got busy=%b valid=%b expected 0 0", cur_busy, cur_valid);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (sel4 !== 3'd0 || busy4 !== 1'b0 || valid4 !== 1'b0 || sample4 !== 8'h00) begin
      errors++;
      $display("FAIL %s: got sel=%0d busy=%b valid=%b sample=%h expected 0 0 0 00",
               tag, sel4, busy4, valid4, sample4);
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; which = 1'b0; start_v = 1'b0; ready_v = 1'b0;
    mask_v = 8'h00; data_v = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    checks++;
    if (busy1 !== 1'b0 || valid1 !== 1'b0 || sample1 !== 8'h00) begin
      errors++; $display("FAIL reset_state_d1: got busy=%b valid=%b sample=%h expected 0 0 00", busy1, valid1, sample1);
    end
    rst = 1'b0;
    // Start a scan and reset it while channel 3 is selected.
    @(negedge clk);
    mask_v = 8'hFF; data_v = 8'hFF; start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    n = 0;
    while (sel4 !== 3'd3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sel4 !== 3'd3) begin
      errors++; $display("FAIL reach_sel3: got %0d expected 3", sel4);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_scan");
    @(negedge clk);
    rst = 1'b0;
    scan(1'b0, 8'h0C, 8'hFF, 8'h0C, 0, 1'b0);
  endtask

  task automatic test_full_scan();
    scan(1'b0, 8'hFF, 8'hA5, 8'hFF, 0, 1'b0);
  endtask

  task automatic test_sparse();
    scan(1'b0, 8'h81, 8'hFF, 8'h81, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    scan(1'b0, 8'h06, 8'h04, 8'h06, 10, 1'b0);
  endtask

  task automatic test_mask_zero();
    @(negedge clk);
    which = 1'b0; mask_v = 8'h00; start_v = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy4 !== 1'b0 || valid4 !== 1'b0) begin
        errors++; $display("FAIL mask_zero: got busy=%b valid=%b expected 0 0", busy4, valid4);
      end
    end
    start_v = 1'b0;
  endtask

  task automatic test_dwell1();
    scan(1'b1, 8'h0F, 8'h0A, 8'h0F, 2, 1'b0);
  endtask

  task automatic test_mask_change();
    scan(1'b0, 8'h30, 8'hFF, 8'hFF, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    scan(1'b0, 8'h03, 8'h02, 8'h03, 0, 1'b0);
    scan(1'b0, 8'h01, 8'h02, 8'h01, 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_sparse();
    test_backpressure();
    test_mask_zero();
    test_dwell1();
    test_mask_change();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_scan_seq.md
# mux_scan_seq

Channel scan sequencer that drives the 3-bit select of the 8:1 mux and samples its single-bit output. It steps through the channels enabled by a mask, holds each select value for a programmable dwell time, and captures the mux output on the last dwell cycle. It then presents the assembled 8-bit snapshot through a valid/ready handshake. It sits directly upstream of the mux select and directly downstream of the mux output.

## Interface
Parameters:
- DWELL, default 4: cycles each channel's select is held. Legal range 1..256.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a scan; sampled only in IDLE.
- mask  input  8  channel enable mask, bit i = channel i; latched on an accepted start.
- sel  output  3  select to the mux `s` port.
- x_in  input  1  mux output `x`.
- busy  output  1  high in DWELL and OUT states.
- sample  output  8  snapshot; bit i = captured x for channel i, 0 for masked-off channels.
- sample_valid  output  1  snapshot available.
- sample_ready  input  1  consumer accepts the snapshot.

## Operation
- States: IDLE, DWELL, OUT.
- Reset values: state IDLE, sel 0, busy 0, sample 8'h00, sample_valid 0, dwell counter 0, latched mask 0.
- IDLE:
  - start=1 with mask≠0: latch mask, clear sample, set sel to the lowest set mask bit, clear the counter, go to DWELL.
  - start=1 with mask=0: ignored; stay in IDLE.
- DWELL:
  - Counter increments each cycle.
  - On cnt==DWELL-1: write x_in into sample[sel] and clear the counter.
  - If a higher latched mask bit exists, load sel with the next higher set bit and stay in DWELL.
  - Otherwise go to OUT.
  - Channels are always scanned ascending; skipped channels cost zero cycles.
- OUT:
  - sample_valid=1; sample and sel are held stable.
  - When sample_valid && sample_ready, go to IDLE, or restart per Configuration.
- start outside IDLE is ignored. Changes to mask after the start is accepted have no effect on the current scan.
- Counter width is max(1, $clog2(DWELL)). With DWELL=1, capture happens in the first and only cycle of each channel.
- Asserting rst mid-scan or in OUT immediately returns every register to its reset value. No partial snapshot is emitted.

## Timing
- start accepted in cycle T:
  - First sel is valid from cycle T+1.
  - The capture for the n-th enabled channel occurs in cycle T+n·DWELL.
  - With k enabled channels, sample_valid rises in cycle T+k·DWELL+1.
- Example, mask=8'hFF, DWELL=4: sample_valid is high from T+33.
- Each select value is held for exactly DWELL cycles. The capture falls on the last of them, giving the mux DWELL-1 cycles to settle.
- Handshake:
  - The transfer completes in the cycle where valid and ready are both high.
  - sample_valid may not drop without that transfer.
  - If ready is held high, OUT lasts one cycle.
- busy falls in the cycle after the transfer; IDLE accepts start in that same cycle.

## Configuration
- Macro: MUX_SCAN_CONT_EN.
- Defined: after a handshake in OUT, the FSM re-enters DWELL directly:
  - It reuses the latched mask.
  - sel is set to the lowest set bit and sample is cleared.
  - start is required only for the first scan.
  - Back-to-back snapshot period is k·DWELL+1 cycles when ready is held high.
  - The only ways back to IDLE are rst, or start=0 sampled together with the handshake.
- Not defined: OUT always returns to IDLE, and every scan needs its own start pulse.

## Test plan
- Reset mid-scan: assert rst while in DWELL with sel=3 → same cycle: sel=0, busy=0, sample_valid=0, sample=8'h00; a later start begins a fresh scan from the lowest mask bit.
- Full scan: DWELL=4, mask=8'hFF, a behavioural 8:1 mux fed 8'hA5 → sel walks 0..7, changing every 4 cycles; sample_valid at T+33 with sample=8'hA5.
- Sparse mask: mask=8'h81, mux data 8'hFF → sel=0 then 7; sample_valid at T+9 with sample=8'h81.
- Backpressure: hold sample_ready=0 for 10 cycles in OUT, then pulse it → sample and sel stay stable; IDLE is entered on the next cycle. A start pulsed while busy is ignored.
- Edge configs:
  - mask=8'h00 with start → stays IDLE, busy=0.
  - DWELL=1, mask=8'h0F → sample_valid at T+5.
  - mask changed mid-scan → no effect on the current scan.
- With MUX_SCAN_CONT_EN defined, mask=8'h03, DWELL=2, ready held high → sample_valid pulses every 5 cycles with no further start.
